// File: rtl/mfp_button_events_if.sv
// Bus between the button event capture stage and the GPIO/interrupt register file.
interface mfp_button_events_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] ie;
  logic [WIDTH-1:0] clr_press;
  logic [WIDTH-1:0] clr_release;
  logic [WIDTH-1:0] clr_hold;
  logic [WIDTH-1:0] press_pend;
  logic [WIDTH-1:0] release_pend;
  logic [WIDTH-1:0] hold_pend;
  logic [WIDTH-1:0] lost;
  logic             irq;

  modport master (
    output in, ie, clr_press, clr_release, clr_hold,
    input  press_pend, release_pend, hold_pend, lost, irq
  );

  modport slave (
    input  in, ie, clr_press, clr_release, clr_hold,
    output press_pend, release_pend, hold_pend, lost, irq
  );
endinterface

// File: rtl/mfp_button_events.sv
// Per-pin press/release/long-press detection with sticky pending bits and a level IRQ.
module mfp_button_events #(
  parameter int WIDTH       = 5,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input logic               clk,
  input logic               rst,
  mfp_button_events_if.slave bus
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_M1  = HW'(HOLD_CYCLES - 1);

  logic                   armed;
  logic [WIDTH-1:0]       in_p1;
  logic [WIDTH-1:0][HW-1:0] cnt;
  logic [WIDTH-1:0][HW-1:0] cnt_nxt;
  logic [WIDTH-1:0]       rise;
  logic [WIDTH-1:0]       fall;
  logic [WIDTH-1:0]       hold_evt;
  logic [WIDTH-1:0]       press_p1;
  logic [WIDTH-1:0]       release_p1;
  logic [WIDTH-1:0]       hold_p1;
  logic [WIDTH-1:0]       lost_p1;
  logic                   irq_p2;

  // Stage 0: edge and hold detection on the incoming levels
  always_comb begin
    rise     = '0;
    fall     = '0;
    hold_evt = '0;
    cnt_nxt  = '0;
    if (armed) begin
      rise = bus.in & ~in_p1;
      fall = ~bus.in & in_p1;
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.in[i]) begin
        cnt_nxt[i]  = (cnt[i] != HOLD_MAX) ? cnt[i] + HW'(1) : cnt[i];
        // Fires only on the step into saturation, so once per continuous high
        hold_evt[i] = (cnt[i] == HOLD_M1);
      end
    end
  end

  // Stage 1: sticky pending bits; a new event wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      armed      <= 1'b0;
      in_p1      <= '0;
      cnt        <= '0;
      press_p1   <= '0;
      release_p1 <= '0;
      hold_p1    <= '0;
      lost_p1    <= '0;
      irq_p2     <= 1'b0;
    end else begin
      armed      <= 1'b1;
      in_p1      <= bus.in;
      cnt        <= cnt_nxt;
      press_p1   <= rise | (press_p1 & ~bus.clr_press);
      release_p1 <= fall | (release_p1 & ~bus.clr_release);
      hold_p1    <= hold_evt | (hold_p1 & ~bus.clr_hold);
      lost_p1    <= (rise & press_p1) | (lost_p1 & ~bus.clr_press);
      // Stage 2: interrupt level from the already-registered pending bits
      irq_p2     <= |((press_p1 | release_p1 | hold_p1) & bus.ie);
    end
  end

  assign bus.press_pend   = press_p1;
  assign bus.release_pend = release_p1;
  assign bus.hold_pend    = hold_p1;
  assign bus.lost         = lost_p1;
  assign bus.irq          = irq_p2;
endmodule
